// File: rtl/tp_mul_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the TrackletProcessor
// multiplier-sharing arbiter.
package tp_mul_arb_pkg;

    localparam int unsigned MUL_A_W   = 18;
    localparam int unsigned MUL_B_W   = 18;
    localparam int unsigned MUL_P_W   = 32;
    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned ID_MAX_W  = 3;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [MUL_P_W-1:0]  p;
    } mul_res_t;

    // First asserted valid at or after ptr, wrapping modulo nreq; one-hot or zero.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]  valid,
                                                   input logic [ID_MAX_W-1:0] ptr,
                                                   input int unsigned         nreq);
        logic [MAX_REQ-1:0]  gnt;
        logic [ID_MAX_W-1:0] idx;
        gnt = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = ID_MAX_W'((32'(ptr) + k) % nreq);
            if (k < nreq && gnt == '0 && valid[idx]) begin
                gnt[idx] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/tp_mul_pipe.sv
// LAT-stage signed 18x18 multiplier carrying a valid bit and requester ID alongside
// the product; valids clear synchronously on ap_rst.
module tp_mul_pipe
    import tp_mul_arb_pkg::*;
#(
    parameter int unsigned LAT = 3
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic                       valid_i,
    input  logic [ID_MAX_W-1:0]        id_i,
    input  logic signed [MUL_A_W-1:0]  a_i,
    input  logic signed [MUL_B_W-1:0]  b_i,
    output logic                       valid_o,
    output mul_res_t                   res_o,
    output logic [LAT-1:0]             stage_valid_o
);

    logic signed [MUL_A_W+MUL_B_W-1:0] prod_full;
    logic [LAT-1:0]                    vld_q;
    mul_res_t                          stage_q [LAT];

    assign prod_full = a_i * b_i;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            for (int unsigned i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Data stages are not reset; only the valids decide what reaches the FIFO.
    always_ff @(posedge ap_clk) begin
        stage_q[0] <= '{id: id_i, p: MUL_P_W'(prod_full)};
        for (int unsigned i = 1; i < LAT; i++) begin
            stage_q[i] <= stage_q[i-1];
        end
    end

    assign valid_o       = vld_q[LAT-1];
    assign res_o         = stage_q[LAT-1];
    assign stage_valid_o = vld_q;

endmodule

// File: rtl/tp_mul_share_arbiter.sv
// Round-robin, credit-limited sharing of one pipelined multiplier among NREQ requesters,
// with ID-tagged results delivered through a show-ahead FIFO.
module tp_mul_share_arbiter
    import tp_mul_arb_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned LAT        = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*MUL_A_W-1:0]   req_a,
    input  logic [NREQ*MUL_B_W-1:0]   req_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [$clog2(NREQ)-1:0]   res_id,
    output logic [MUL_P_W-1:0]        res_p,
    output logic                      busy
);

    localparam int unsigned ID_W = $clog2(NREQ);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]            credits_q, credits_d;
    logic [MAX_REQ-1:0]       pick;
    logic [NREQ-1:0]          gnt;
    logic                     issue, pop;
    logic [ID_MAX_W-1:0]      gnt_id;
    logic signed [MUL_A_W-1:0] a_sel;
    logic signed [MUL_B_W-1:0] b_sel;

    logic                     wr_en;
    mul_res_t                 pipe_res;
    logic [LAT-1:0]           pipe_valid;
    logic [AW:0]              wr_ptr_q, rd_ptr_q;
    mul_res_t                 mem_q [FIFO_DEPTH];
    mul_res_t                 head;
    logic                     fifo_empty, fifo_full;

    // Grant depends only on registered ptr/credits and req_valid, never on res_ready.
    always_comb begin
        pick = '0;
        if (!ap_rst && credits_q != '0) begin
            pick = rr_pick(MAX_REQ'(req_valid), ID_MAX_W'(ptr_q), NREQ);
        end
        gnt    = NREQ'(pick);
        issue  = |(gnt & req_valid);
        gnt_id = '0;
        a_sel  = '0;
        b_sel  = '0;
        ptr_d  = ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_id = ID_MAX_W'(i);
                a_sel  = req_a[i*MUL_A_W +: MUL_A_W];
                b_sel  = req_b[i*MUL_B_W +: MUL_B_W];
                ptr_d  = ID_W'((i + 1) % NREQ);
            end
        end
        pop       = ~fifo_empty & res_ready;
        credits_d = credits_q - CW'(issue) + CW'(pop);
    end

    assign req_ready = gnt;

    tp_mul_pipe #(
        .LAT (LAT)
    ) u_pipe (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .valid_i       (issue),
        .id_i          (gnt_id),
        .a_i           (a_sel),
        .b_i           (b_sel),
        .valid_o       (wr_en),
        .res_o         (pipe_res),
        .stage_valid_o (pipe_valid)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr_q     <= '0;
            credits_q <= CW'(FIFO_DEPTH);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= pipe_res;
        end
    end

    always_comb begin
        head       = mem_q[rd_ptr_q[AW-1:0]];
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        res_valid  = ~fifo_empty;
        res_id     = res_valid ? ID_W'(head.id) : '0;
        res_p      = res_valid ? head.p : '0;
        busy       = (|pipe_valid) | ~fifo_empty;
    end

    // Credits bound pipeline + FIFO occupancy, so a write never lands on a full FIFO.
    assert property (@(posedge ap_clk) disable iff (ap_rst) !(wr_en && fifo_full && !pop));

endmodule
